// File: rtl/iq_window_integrator.sv
// iq_window_integrator: sums signed baseband I/Q samples over a programmable
// window that starts after a readout trigger. A programmable number of valid
// samples is skipped first. The block then produces one saturated
// (i_val, q_val) point per trigger, marked by a one-cycle iq_valid strobe.
module iq_window_integrator #(
  parameter int SAMPLE_W = 16,
  parameter int ACC_W    = 32,
  parameter int LEN_W    = 16
) (
  input  logic                clk100,
  input  logic                rst_n,
  input  logic                trig,
  input  logic [LEN_W-1:0]    delay_len,
  input  logic [LEN_W-1:0]    int_len,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] i_sample,
  input  logic [SAMPLE_W-1:0] q_sample,
  output logic                busy,
  output logic                iq_valid,
  output logic [ACC_W-1:0]    i_val,
  output logic [ACC_W-1:0]    q_val,
  output logic                sat,
  output logic                trig_miss
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_INTEG = 2'd2
  } state_t;

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [LEN_W-1:0]        LEN_ONE = LEN_W'(1);

  // Widen a raw sample to accumulator width, keeping its sign.
  function automatic logic signed [ACC_W-1:0] sext(input logic [SAMPLE_W-1:0] s);
    sext = {{(ACC_W-SAMPLE_W){s[SAMPLE_W-1]}}, s};
  endfunction

  // Add with one guard bit, then clamp. The MSB of the result flags a clamp.
  function automatic logic [ACC_W:0] sat_add(input logic signed [ACC_W-1:0] a,
                                             input logic signed [ACC_W-1:0] b);
    logic signed [ACC_W:0] sum;
    sum = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    if (sum[ACC_W] != sum[ACC_W-1]) begin
      sat_add = {1'b1, (sum[ACC_W] ? ACC_MIN : ACC_MAX)};
    end else begin
      sat_add = {1'b0, sum[ACC_W-1:0]};
    end
  endfunction

  state_t                    state_q, state_d;
  logic [LEN_W-1:0]          dly_cnt_q, dly_cnt_d;
  logic [LEN_W-1:0]          int_cnt_q, int_cnt_d;
  logic signed [ACC_W-1:0]   acc_i_q, acc_i_d;
  logic signed [ACC_W-1:0]   acc_q_q, acc_q_d;
  logic                      sat_i_q, sat_i_d;
  logic                      sat_q_q, sat_q_d;
  logic                      busy_q, busy_d;
  logic                      iq_valid_q, iq_valid_d;
  logic signed [ACC_W-1:0]   i_val_q, i_val_d;
  logic signed [ACC_W-1:0]   q_val_q, q_val_d;
  logic                      sat_out_q, sat_out_d;
  logic                      trig_miss_q, trig_miss_d;

  logic [ACC_W:0]            add_i;
  logic [ACC_W:0]            add_q;

  assign add_i = sat_add(acc_i_q, sext(i_sample));
  assign add_q = sat_add(acc_q_q, sext(q_sample));

  // State register.
  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: only valid samples advance the window; gaps stall in place.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (trig) begin
          if (delay_len != '0)    state_d = ST_DELAY;
          else if (int_len != '0) state_d = ST_INTEG;
          else                    state_d = ST_IDLE;
        end
      end
      ST_DELAY: begin
        if (sample_valid && (dly_cnt_q == LEN_ONE)) begin
          state_d = (int_cnt_q != '0) ? ST_INTEG : ST_IDLE;
        end
      end
      ST_INTEG: begin
        if (sample_valid && (int_cnt_q == LEN_ONE)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath and outputs: counters, clamped accumulation, result capture.
  always_comb begin
    dly_cnt_d   = dly_cnt_q;
    int_cnt_d   = int_cnt_q;
    acc_i_d     = acc_i_q;
    acc_q_d     = acc_q_q;
    sat_i_d     = sat_i_q;
    sat_q_d     = sat_q_q;
    busy_d      = busy_q;
    iq_valid_d  = 1'b0;
    i_val_d     = i_val_q;
    q_val_d     = q_val_q;
    sat_out_d   = sat_out_q;
    trig_miss_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (trig) begin
          dly_cnt_d = delay_len;
          int_cnt_d = int_len;
          acc_i_d   = '0;
          acc_q_d   = '0;
          sat_i_d   = 1'b0;
          sat_q_d   = 1'b0;
          busy_d    = 1'b1;
          // An empty window with no delay completes on the trigger edge.
          if ((delay_len == '0) && (int_len == '0)) begin
            busy_d     = 1'b0;
            iq_valid_d = 1'b1;
            i_val_d    = '0;
            q_val_d    = '0;
            sat_out_d  = 1'b0;
          end
        end
      end
      ST_DELAY: begin
        trig_miss_d = trig;
        if (sample_valid) begin
          dly_cnt_d = dly_cnt_q - LEN_ONE;
          // Empty window after a delay completes on the last discarded sample.
          if ((dly_cnt_q == LEN_ONE) && (int_cnt_q == '0)) begin
            busy_d     = 1'b0;
            iq_valid_d = 1'b1;
            i_val_d    = '0;
            q_val_d    = '0;
            sat_out_d  = 1'b0;
          end
        end
      end
      ST_INTEG: begin
        trig_miss_d = trig;
        if (sample_valid) begin
          int_cnt_d = int_cnt_q - LEN_ONE;
          acc_i_d   = add_i[ACC_W-1:0];
          acc_q_d   = add_q[ACC_W-1:0];
          sat_i_d   = sat_i_q | add_i[ACC_W];
          sat_q_d   = sat_q_q | add_q[ACC_W];
          // The result includes the sample accepted on this edge.
          if (int_cnt_q == LEN_ONE) begin
            busy_d     = 1'b0;
            iq_valid_d = 1'b1;
            i_val_d    = add_i[ACC_W-1:0];
            q_val_d    = add_q[ACC_W-1:0];
            sat_out_d  = sat_i_q | add_i[ACC_W] | sat_q_q | add_q[ACC_W];
          end
        end
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      dly_cnt_q   <= '0;
      int_cnt_q   <= '0;
      acc_i_q     <= '0;
      acc_q_q     <= '0;
      sat_i_q     <= 1'b0;
      sat_q_q     <= 1'b0;
      busy_q      <= 1'b0;
      iq_valid_q  <= 1'b0;
      i_val_q     <= '0;
      q_val_q     <= '0;
      sat_out_q   <= 1'b0;
      trig_miss_q <= 1'b0;
    end else begin
      dly_cnt_q   <= dly_cnt_d;
      int_cnt_q   <= int_cnt_d;
      acc_i_q     <= acc_i_d;
      acc_q_q     <= acc_q_d;
      sat_i_q     <= sat_i_d;
      sat_q_q     <= sat_q_d;
      busy_q      <= busy_d;
      iq_valid_q  <= iq_valid_d;
      i_val_q     <= i_val_d;
      q_val_q     <= q_val_d;
      sat_out_q   <= sat_out_d;
      trig_miss_q <= trig_miss_d;
    end
  end

  // busy also covers the cycle in which a trigger is being accepted.
  assign busy      = busy_q | ((state_q == ST_IDLE) & trig);
  assign iq_valid  = iq_valid_q;
  assign i_val     = i_val_q;
  assign q_val     = q_val_q;
  assign sat       = sat_out_q;
  assign trig_miss = trig_miss_q;

endmodule

// File: tb/tb_iq_window_integrator.sv
// Bench for iq_window_integrator: one instance at the default accumulator
// width and one at ACC_W=20 for saturation, driven from the same inputs.
module tb_iq_window_integrator;

  logic        clk100;
  logic        rst_n;
  logic        trig;
  logic [15:0] delay_len;
  logic [15:0] int_len;
  logic        sample_valid;
  logic [15:0] i_sample;
  logic [15:0] q_sample;

  logic        busy32, iqv32, sat32, miss32;
  logic [31:0] i32, q32;
  logic        busy20, iqv20, sat20, miss20;
  logic [19:0] i20, q20;

  iq_window_integrator #(.SAMPLE_W(16), .ACC_W(32), .LEN_W(16)) dut (
    .clk100(clk100), .rst_n(rst_n), .trig(trig), .delay_len(delay_len),
    .int_len(int_len), .sample_valid(sample_valid), .i_sample(i_sample),
    .q_sample(q_sample), .busy(busy32), .iq_valid(iqv32), .i_val(i32),
    .q_val(q32), .sat(sat32), .trig_miss(miss32));

  iq_window_integrator #(.SAMPLE_W(16), .ACC_W(20), .LEN_W(16)) dut20 (
    .clk100(clk100), .rst_n(rst_n), .trig(trig), .delay_len(delay_len),
    .int_len(int_len), .sample_valid(sample_valid), .i_sample(i_sample),
    .q_sample(q_sample), .busy(busy20), .iq_valid(iqv20), .i_val(i20),
    .q_val(q20), .sat(sat20), .trig_miss(miss20));

  initial clk100 = 1'b0;
  always #5 clk100 = ~clk100;

  typedef struct {
    int     dly;
    int     len;
    int     mode;      // 0 continuous, 1 alternate valid, 2 random gaps
    bit     use20;
    bit     mid_trig;
    int     i_base;
    int     i_step;
    int     q_base;
    int     q_step;
    longint exp_i;
    longint exp_q;
    bit     exp_sat;
    int     exp_miss;
  } vec_t;

  vec_t   tbl [8];
  int     n_tests;
  int     n_fail;
  int     obs_strobes, obs_miss, obs_terr, obs_berr;
  longint obs_i, obs_q;
  bit     obs_sat;

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic busy_s(input bit u);
    return u ? busy20 : busy32;
  endfunction

  // One clock: inputs drop back to idle shortly after the edge.
  task automatic step();
    @(posedge clk100);
    #1;
    trig = 1'b0;
    sample_valid = 1'b0;
    #1;
  endtask

  task automatic observe(input bit exp_strobe, input bit u);
    logic v;
    v = u ? iqv20 : iqv32;
    if (u ? miss20 : miss32) obs_miss++;
    if (v !== exp_strobe) obs_terr++;
    if (v) begin
      obs_strobes++;
      obs_i   = u ? longint'($signed(i20)) : longint'($signed(i32));
      obs_q   = u ? longint'($signed(q20)) : longint'($signed(q32));
      obs_sat = u ? sat20 : sat32;
      if (busy_s(u) !== 1'b0) obs_berr++;
    end
  endtask

  // Clamp-accumulate the window's samples the way the block is meant to.
  task automatic model(input int dly, input int len, input int w, input longint s[$],
                       output longint r, output bit st);
    longint hi, lo;
    hi = (longint'(1) <<< (w - 1)) - 1;
    lo = -(longint'(1) <<< (w - 1));
    r = 0;
    st = 1'b0;
    for (int k = dly; k < dly + len; k++) begin
      r = r + s[k];
      if (r > hi) begin r = hi; st = 1'b1; end
      if (r < lo) begin r = lo; st = 1'b1; end
    end
  endtask

  task automatic run_window(input int dly, input int len, input int mode, input bit u,
                            input bit mid_trig, input longint si[$], input longint sq[$]);
    int total, k, cyc;
    bit v;
    total = dly + len;
    k = 0;
    cyc = 0;
    obs_strobes = 0; obs_miss = 0; obs_terr = 0; obs_berr = 0;
    obs_i = 0; obs_q = 0; obs_sat = 1'b0;
    trig = 1'b1;
    delay_len = 16'(dly);
    int_len = 16'(len);
    sample_valid = 1'b1;           // trig-cycle sample must be ignored
    i_sample = 16'h1234;
    q_sample = 16'h4321;
    #1;
    if (busy_s(u) !== 1'b1) obs_berr++;
    step();
    delay_len = 16'($urandom);
    int_len = 16'($urandom);
    observe(total == 0, u);
    while (k < total && cyc < 4000) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      sample_valid = v;
      if (v) begin
        i_sample = 16'(si[k]);
        q_sample = 16'(sq[k]);
        k++;
      end else begin
        i_sample = 16'($urandom);
        q_sample = 16'($urandom);
      end
      if (mid_trig && cyc == 4) trig = 1'b1;
      #1;
      if (busy_s(u) !== 1'b1) obs_berr++;
      step();
      cyc++;
      observe(k == total, u);
    end
    if (k < total) obs_terr++;
    repeat (3) begin
      step();
      observe(1'b0, u);
    end
  endtask

  task automatic check_window(input string tag, input longint ei, input longint eq,
                              input bit es, input int emiss);
    chk({tag, "_i_val"}, obs_i, ei);
    chk({tag, "_q_val"}, obs_q, eq);
    chk({tag, "_sat"}, longint'(obs_sat), longint'(es));
    chk({tag, "_strobes"}, longint'(obs_strobes), 64'sd1);
    chk({tag, "_strobe_timing_errs"}, longint'(obs_terr), 64'sd0);
    chk({tag, "_busy_errs"}, longint'(obs_berr), 64'sd0);
    chk({tag, "_trig_miss"}, longint'(obs_miss), longint'(emiss));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    longint si[$], sq[$];
    longint ri, rq;
    bit     st_i, st_q, u, sgn_i, sgn_q;
    int     dly, len, cnt, mcnt;
    logic [15:0] t;

    n_tests = 0;
    n_fail = 0;
    rst_n = 1'b0;
    trig = 1'b0;
    delay_len = '0;
    int_len = '0;
    sample_valid = 1'b0;
    i_sample = '0;
    q_sample = '0;

    tbl[0] = '{2, 4,  0, 1'b0, 1'b0, 1, 1, -1, -1, 64'sd18, -64'sd18, 1'b0, 0};
    tbl[1] = '{2, 4,  1, 1'b0, 1'b0, 1, 1, -1, -1, 64'sd18, -64'sd18, 1'b0, 0};
    tbl[2] = '{0, 20, 0, 1'b1, 1'b0, 32767, 0, -32768, 0, 64'sd524287, -64'sd524288, 1'b1, 0};
    tbl[3] = '{0, 3,  0, 1'b1, 1'b0, 1, 0, 1, 0, 64'sd3, 64'sd3, 1'b0, 0};
    tbl[4] = '{0, 8,  0, 1'b0, 1'b1, 10, 1, -3, 2, 64'sd108, 64'sd32, 1'b0, 1};
    tbl[5] = '{0, 0,  0, 1'b0, 1'b0, 0, 0, 0, 0, 64'sd0, 64'sd0, 1'b0, 0};
    tbl[6] = '{3, 0,  2, 1'b0, 1'b0, 9, 1, 9, 1, 64'sd0, 64'sd0, 1'b0, 0};
    tbl[7] = '{1, 1,  0, 1'b0, 1'b0, -32768, 0, 32767, 0, -64'sd32768, 64'sd32767, 1'b0, 0};

    // Reset state
    step();
    step();
    chk("reset_busy", longint'(busy32), 64'sd0);
    chk("reset_iq_valid", longint'(iqv32), 64'sd0);
    chk("reset_i_val", longint'($signed(i32)), 64'sd0);
    chk("reset_q_val", longint'($signed(q32)), 64'sd0);
    chk("reset_sat", longint'(sat32), 64'sd0);
    chk("reset_trig_miss", longint'(miss32), 64'sd0);
    rst_n = 1'b1;
    step();

    // Directed table
    for (int r = 0; r < 8; r++) begin
      si.delete();
      sq.delete();
      for (int k = 0; k < tbl[r].dly + tbl[r].len; k++) begin
        si.push_back(longint'(tbl[r].i_base + k * tbl[r].i_step));
        sq.push_back(longint'(tbl[r].q_base + k * tbl[r].q_step));
      end
      run_window(tbl[r].dly, tbl[r].len, tbl[r].mode, tbl[r].use20, tbl[r].mid_trig, si, sq);
      check_window($sformatf("row%0d", r), tbl[r].exp_i, tbl[r].exp_q, tbl[r].exp_sat,
                   tbl[r].exp_miss);
    end

    // Reset in the middle of a window
    trig = 1'b1;
    delay_len = 16'd0;
    int_len = 16'd8;
    step();
    repeat (3) begin
      sample_valid = 1'b1;
      i_sample = 16'd100;
      q_sample = 16'd50;
      step();
    end
    chk("rst_mid_busy_before", longint'(busy32), 64'sd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_i_val", longint'($signed(i32)), 64'sd0);
    chk("rst_mid_q_val", longint'($signed(q32)), 64'sd0);
    chk("rst_mid_busy", longint'(busy32), 64'sd0);
    chk("rst_mid_iq_valid", longint'(iqv32), 64'sd0);
    sample_valid = 1'b1;
    step();
    chk("rst_hold_iq_valid", longint'(iqv32), 64'sd0);
    rst_n = 1'b1;
    step();
    si.delete(); sq.delete();
    si.push_back(64'sd5); si.push_back(64'sd7);
    sq.push_back(64'sd0); sq.push_back(-64'sd2);
    run_window(0, 2, 0, 1'b0, 1'b0, si, sq);
    check_window("after_rst", 64'sd12, -64'sd2, 1'b0, 0);

    // Trigger accepted in the strobe cycle
    trig = 1'b1;
    delay_len = 16'd0;
    int_len = 16'd1;
    step();
    sample_valid = 1'b1;
    i_sample = 16'd4;
    q_sample = 16'hFFFC;
    step();
    chk("strobe_trig_first_valid", longint'(iqv32), 64'sd1);
    chk("strobe_trig_first_i", longint'($signed(i32)), 64'sd4);
    trig = 1'b1;
    delay_len = 16'd0;
    int_len = 16'd0;
    #1;
    chk("strobe_trig_busy", longint'(busy32), 64'sd1);
    step();
    chk("strobe_trig_second_valid", longint'(iqv32), 64'sd1);
    chk("strobe_trig_second_i", longint'($signed(i32)), 64'sd0);
    chk("strobe_trig_miss", longint'(miss32), 64'sd0);
    step();
    chk("strobe_trig_quiet", longint'(iqv32), 64'sd0);

    // Back-to-back empty windows: one strobe per trigger
    cnt = 0;
    mcnt = 0;
    repeat (3) begin
      trig = 1'b1;
      delay_len = 16'd0;
      int_len = 16'd0;
      step();
      if (iqv32) cnt++;
      if (miss32) mcnt++;
    end
    repeat (2) begin
      step();
      if (iqv32) cnt++;
      if (miss32) mcnt++;
    end
    chk("b2b_zero_strobes", longint'(cnt), 64'sd3);
    chk("b2b_zero_miss", longint'(mcnt), 64'sd0);

    // Randomized windows against the reference model
    for (int r = 0; r < 30; r++) begin
      u = r[0];
      dly = $urandom_range(0, 4);
      len = u ? $urandom_range(0, 40) : $urandom_range(0, 12);
      sgn_i = $urandom_range(0, 1);
      sgn_q = $urandom_range(0, 1);
      si.delete();
      sq.delete();
      for (int k = 0; k < dly + len; k++) begin
        if (!u || $urandom_range(0, 4) == 0) begin
          t = 16'($urandom);
          si.push_back(longint'($signed(t)));
          t = 16'($urandom);
          sq.push_back(longint'($signed(t)));
        end else begin
          si.push_back(sgn_i ? longint'($urandom_range(20000, 32767))
                             : -longint'($urandom_range(20000, 32768)));
          sq.push_back(sgn_q ? longint'($urandom_range(20000, 32767))
                             : -longint'($urandom_range(20000, 32768)));
        end
      end
      model(dly, len, u ? 20 : 32, si, ri, st_i);
      model(dly, len, u ? 20 : 32, sq, rq, st_q);
      run_window(dly, len, 2, u, 1'b0, si, sq);
      check_window($sformatf("rand%0d", r), ri, rq, st_i | st_q, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/iq_window_integrator.md
Name: iq_window_integrator

Overview:
- Upstream front end for the readout classifier.
- Accumulates signed baseband I/Q samples over a programmable window after a readout trigger. One window produces one integrated (i_val, q_val) point with a one-cycle valid strobe.
- Outputs connect directly to the classifier's data_in / i_val / q_val inputs.
- One result per trigger. Windows are software-programmed per shot.

Parameters:
- SAMPLE_W, 16, width of signed input I/Q samples.
- ACC_W, 32, width of signed accumulators and i_val/q_val outputs. Must satisfy ACC_W > SAMPLE_W.
- LEN_W, 16, width of the delay and window-length counters.

Ports:
- clk100  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- trig  in  1  readout trigger pulse; starts a window when the block is idle.
- delay_len  in  LEN_W  number of valid samples to discard after trig; latched on an accepted trig.
- int_len  in  LEN_W  number of valid samples to integrate; latched on an accepted trig.
- sample_valid  in  1  qualifies i_sample/q_sample this cycle.
- i_sample  in  SAMPLE_W  signed in-phase sample.
- q_sample  in  SAMPLE_W  signed quadrature sample.
- busy  out  1  high from an accepted trig until the result strobe.
- iq_valid  out  1  one-cycle strobe; i_val/q_val are new this cycle. Feeds the classifier's data_in.
- i_val  out  ACC_W  signed integrated I; holds until the next result.
- q_val  out  ACC_W  signed integrated Q; holds until the next result.
- sat  out  1  the current result saturated in I or Q; updates with iq_valid.
- trig_miss  out  1  one-cycle pulse when trig arrives while busy.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - busy, iq_valid, sat, trig_miss = 0.
  - i_val, q_val, accumulators, counters = 0.
  - Reset mid-window aborts the window with no strobe.
- States: IDLE, DELAY, INTEG.
- IDLE:
  - On trig=1, latch delay_len and int_len, clear accumulators and the sat flags, set busy.
  - Next state: DELAY if delay_len>0; else INTEG if int_len>0; else the zero-length case below.
  - A sample with sample_valid on the trig cycle is NOT counted. Counting starts the cycle after trig.
- DELAY:
  - Each sample_valid=1 decrements the delay counter; the sample is discarded.
  - On the last discarded sample: INTEG if int_len>0, else the zero-length case.
- INTEG:
  - Each sample_valid=1 adds the sign-extended samples: acc_i += i_sample, acc_q += q_sample.
  - On the edge accepting the last sample (int_len-th valid): i_val/q_val <= the final sums including that sample, iq_valid <= 1, busy <= 0, state <= IDLE.
  - Latency: iq_valid is high in the cycle immediately after the last sample's edge.
- Zero-length window (int_len=0): emit i_val=q_val=0, sat=0, iq_valid=1 on the edge where the window would start (after trig if delay_len=0, otherwise after the last delay sample). Return to IDLE.
- Gaps: sample_valid=0 cycles stall the counters in any state. No timeout.
- Saturation:
  - Each addition clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1], per channel.
  - A clamped accumulator stays clamped on further same-sign adds and recovers normally on opposite-sign adds (clamp the sum each step).
  - sat = OR of sticky per-channel clamp flags for the window; registered with iq_valid.
- trig while busy (DELAY/INTEG): ignored; trig_miss=1 for one cycle; the window is unaffected.
- trig in the same cycle iq_valid is asserted: the block is IDLE then, so the trig is accepted.
- Changes to delay_len/int_len during a window have no effect on that window.
- iq_valid never asserts on two consecutive cycles unless int_len=0 and trig is back-to-back. In that case one strobe per accepted trig.

Test Plan:
- delay_len=2, int_len=4; i_sample=1..6 and q_sample=-1..-6 on consecutive valid cycles after trig -> iq_valid one cycle after the 6th sample; i_val=18, q_val=-18, sat=0.
- Same window with sample_valid toggled 1/0 every cycle -> identical result, strobe delayed to one cycle after the 6th valid sample. busy high throughout.
- ACC_W=20, delay_len=0, int_len=20, i_sample=32767, q_sample=-32768 constant -> i_val=524287, q_val=-524288, sat=1. The next window with i=q=1, int_len=3 gives i_val=q_val=3, sat=0.
- trig pulsed again mid-INTEG of a delay_len=0, int_len=8 window -> trig_miss pulses once; result equals the single-window sum; exactly one iq_valid.
- rst_n pulsed low after 3 of 8 integrated samples -> outputs 0 immediately, no iq_valid. A fresh trig with int_len=2, samples 5 and 7 gives i_val=12.
- int_len=0, delay_len=0, trig -> iq_valid on the next cycle with i_val=q_val=0, busy high for exactly one cycle.
